// File: rtl/lcd_spi_rx_if.sv
// lcd_spi_rx_if: SPI link pins plus the decoded byte/pixel/status outputs of the LCD receiver.
interface lcd_spi_rx_if #(parameter int COORD_W = 9);
   logic               spi_sclk;
   logic               spi_cs_n;
   logic               spi_dc;
   logic               spi_mosi;
   logic               byte_valid;
   logic [7:0]         byte_data;
   logic               byte_dc;
   logic               pix_valid;
   logic [COORD_W-1:0] pix_x;
   logic [COORD_W-1:0] pix_y;
   logic [15:0]        pix_rgb;
   logic               frame_done;
   logic               sleep_out;
   logic               disp_on;
   logic [7:0]         madctl;
   logic [7:0]         colmod;
   modport master (
      output spi_sclk, spi_cs_n, spi_dc, spi_mosi,
      input  byte_valid, byte_data, byte_dc, pix_valid, pix_x, pix_y, pix_rgb,
             frame_done, sleep_out, disp_on, madctl, colmod
   );
   modport slave (
      input  spi_sclk, spi_cs_n, spi_dc, spi_mosi,
      output byte_valid, byte_data, byte_dc, pix_valid, pix_x, pix_y, pix_rgb,
             frame_done, sleep_out, disp_on, madctl, colmod
   );
endinterface

// File: rtl/lcd_spi_rx.sv
// lcd_spi_rx: oversampling ST7789-style SPI receiver; reassembles bytes, decodes the panel
// command subset and streams RGB565 pixels with their window coordinates.
module lcd_spi_rx #(
   parameter int COORD_W = 9,
   parameter int DEF_XE  = 239,
   parameter int DEF_YE  = 319
) (
   input  logic         clk,
   input  logic         resetn,
   lcd_spi_rx_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, PARAM, RAMWR} state_t;
   // sync vectors are {cs_n, sclk, dc, mosi}; cs_n resets high so nothing is seen as selected
   logic [3:0]         s1_q, s2_q;
   logic               sclk_prev_q;
   logic [6:0]         sr_q;
   logic [2:0]         cnt_q;
   logic               byte_valid_q, byte_dc_q;
   logic [7:0]         byte_data_q;
   state_t             state_q;
   logic [7:0]         cmd_q, hi_q, madctl_q, colmod_q;
   logic [2:0]         pidx_q;
   logic               phase_q, sleep_q, disp_q, pix_valid_q, frame_done_q;
   logic [15:0]        xs_q, xe_q, ys_q, ye_q, pix_rgb_q;
   logic [COORD_W-1:0] x_q, y_q, pix_x_q, pix_y_q;
   logic [COORD_W-1:0] xs, xe, ys, ye, x_d, y_d;
   logic               edge_det, wrap_x, last_d;
   always_comb begin
      edge_det = s2_q[2] && !sclk_prev_q && !s2_q[3];
      xs       = COORD_W'(xs_q);
      xe       = COORD_W'(xe_q);
      ys       = COORD_W'(ys_q);
      ye       = COORD_W'(ye_q);
      wrap_x   = x_q == xe;
      x_d      = wrap_x ? xs : x_q + 1'b1;
      y_d      = wrap_x ? ((y_q == ye) ? ys : y_q + 1'b1) : y_q;
      last_d   = wrap_x && (y_q == ye);
   end
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s1_q         <= 4'b1000;
         s2_q         <= 4'b1000;
         sclk_prev_q  <= 1'b0;
         sr_q         <= '0;
         cnt_q        <= '0;
         byte_valid_q <= 1'b0;
         byte_data_q  <= '0;
         byte_dc_q    <= 1'b0;
      end else begin
         s1_q         <= {bus.spi_cs_n, bus.spi_sclk, bus.spi_dc, bus.spi_mosi};
         s2_q         <= s1_q;
         sclk_prev_q  <= s2_q[2];
         byte_valid_q <= 1'b0;
         if (s2_q[3]) begin
            cnt_q <= '0;
         end else if (edge_det) begin
            sr_q  <= {sr_q[5:0], s2_q[0]};
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               byte_valid_q <= 1'b1;
               byte_data_q  <= {sr_q, s2_q[0]};
               byte_dc_q    <= s2_q[1];
            end
         end
      end
   end
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= IDLE;
         cmd_q        <= '0;
         pidx_q       <= '0;
         phase_q      <= 1'b0;
         hi_q         <= '0;
         sleep_q      <= 1'b0;
         disp_q       <= 1'b0;
         madctl_q     <= '0;
         colmod_q     <= '0;
         xs_q         <= '0;
         ys_q         <= '0;
         xe_q         <= 16'(DEF_XE);
         ye_q         <= 16'(DEF_YE);
         x_q          <= '0;
         y_q          <= '0;
         pix_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         pix_x_q      <= '0;
         pix_y_q      <= '0;
         pix_rgb_q    <= '0;
      end else begin
         pix_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         if (byte_valid_q && !byte_dc_q) begin
            cmd_q   <= byte_data_q;
            pidx_q  <= '0;
            phase_q <= 1'b0;
            case (byte_data_q)
               8'h11: begin sleep_q <= 1'b1; state_q <= IDLE; end
               8'h10: begin sleep_q <= 1'b0; state_q <= IDLE; end
               8'h29: begin disp_q  <= 1'b1; state_q <= IDLE; end
               8'h28: begin disp_q  <= 1'b0; state_q <= IDLE; end
               8'h2C: begin x_q <= xs; y_q <= ys; state_q <= RAMWR; end
               default: state_q <= PARAM;
            endcase
         end else if (byte_valid_q && state_q == PARAM) begin
            if (pidx_q != 3'd4) pidx_q <= pidx_q + 3'd1;
            if (cmd_q == 8'h36 && pidx_q == 3'd0) madctl_q <= byte_data_q;
            if (cmd_q == 8'h3A && pidx_q == 3'd0) colmod_q <= byte_data_q;
            if (cmd_q == 8'h2A) begin
               if (pidx_q == 3'd0) xs_q[15:8] <= byte_data_q;
               if (pidx_q == 3'd1) xs_q[7:0]  <= byte_data_q;
               if (pidx_q == 3'd2) xe_q[15:8] <= byte_data_q;
               if (pidx_q == 3'd3) xe_q[7:0]  <= byte_data_q;
            end
            if (cmd_q == 8'h2B) begin
               if (pidx_q == 3'd0) ys_q[15:8] <= byte_data_q;
               if (pidx_q == 3'd1) ys_q[7:0]  <= byte_data_q;
               if (pidx_q == 3'd2) ye_q[15:8] <= byte_data_q;
               if (pidx_q == 3'd3) ye_q[7:0]  <= byte_data_q;
            end
         end else if (byte_valid_q && state_q == RAMWR) begin
            phase_q <= !phase_q;
            if (!phase_q) begin
               hi_q <= byte_data_q;
            end else begin
               pix_valid_q  <= 1'b1;
               frame_done_q <= last_d;
               pix_x_q      <= x_q;
               pix_y_q      <= y_q;
               pix_rgb_q    <= {hi_q, byte_data_q};
               x_q          <= x_d;
               y_q          <= y_d;
            end
         end
      end
   end
   assign bus.byte_valid = byte_valid_q;
   assign bus.byte_data  = byte_data_q;
   assign bus.byte_dc    = byte_dc_q;
   assign bus.pix_valid  = pix_valid_q;
   assign bus.pix_x      = pix_x_q;
   assign bus.pix_y      = pix_y_q;
   assign bus.pix_rgb    = pix_rgb_q;
   assign bus.frame_done = frame_done_q;
   assign bus.sleep_out  = sleep_q;
   assign bus.disp_on    = disp_q;
   assign bus.madctl     = madctl_q;
   assign bus.colmod     = colmod_q;
endmodule

// File: tb/tb_lcd_spi_rx.sv
// tb_lcd_spi_rx: directed byte-stream vectors with hand-computed pixels, plus corner sequences
// for partial bytes, aborted pixels and mid-frame reset.
module tb_lcd_spi_rx;
   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;
   lcd_spi_rx_if #(.COORD_W(9)) bus ();
   lcd_spi_rx #(.COORD_W(9), .DEF_XE(239), .DEF_YE(319)) dut (.clk(clk), .resetn(resetn), .bus(bus));
   typedef struct {
      logic        dc;
      logic [7:0]  b;
      logic        pix;
      logic [8:0]  x, y;
      logic [15:0] rgb;
      logic        fd;
   } vec_t;
   vec_t vecs[$];
   int total = 0, bad = 0;
   int pix_cnt = 0, byte_cnt = 0;
   logic [8:0]  lx, ly;
   logic [15:0] lrgb;
   logic        lfd;
   always @(negedge clk) begin
      if (bus.pix_valid) begin
         pix_cnt++;
         lx   = bus.pix_x;
         ly   = bus.pix_y;
         lrgb = bus.pix_rgb;
         lfd  = bus.frame_done;
      end
      if (bus.byte_valid) byte_cnt++;
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic send_bits(input logic dc, input logic [7:0] b, input int n);
      for (int i = 7; i > 7 - n; i--) begin
         @(posedge clk); #1;
         bus.spi_cs_n = 1'b0;
         bus.spi_dc   = dc;
         bus.spi_mosi = b[i];
         bus.spi_sclk = 1'b0;
         repeat (3) @(posedge clk);
         #1 bus.spi_sclk = 1'b1;
         repeat (3) @(posedge clk);
      end
      #1;
      bus.spi_sclk = 1'b0;
      bus.spi_cs_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
   endtask
   task automatic send_byte(input logic dc, input logic [7:0] b);
      send_bits(dc, b, 8);
   endtask
   task automatic add(input logic dc, input logic [7:0] b, input logic pix,
                      input logic [8:0] x, input logic [8:0] y, input logic [15:0] rgb, input logic fd);
      vec_t v;
      v.dc = dc; v.b = b; v.pix = pix; v.x = x; v.y = y; v.rgb = rgb; v.fd = fd;
      vecs.push_back(v);
   endtask
   task automatic nop(input logic dc, input logic [7:0] b);
      add(dc, b, 1'b0, 9'd0, 9'd0, 16'h0, 1'b0);
   endtask
   initial begin
      int bc, pc;
      resetn = 1'b0;
      bus.spi_cs_n = 1'b1; bus.spi_sclk = 1'b0; bus.spi_dc = 1'b0; bus.spi_mosi = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst byte_valid", bus.byte_valid, 0);
      chk("rst pix_valid", bus.pix_valid, 0);
      chk("rst sleep_out", bus.sleep_out, 0);
      chk("rst disp_on", bus.disp_on, 0);
      chk("rst madctl", bus.madctl, 0);
      chk("rst pix_rgb", bus.pix_rgb, 0);
      resetn = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      bc = byte_cnt;
      send_byte(1'b0, 8'h11);
      chk("slpout byte count", byte_cnt - bc, 1);
      chk("slpout byte_dc", bus.byte_dc, 0);
      chk("slpout byte_data", bus.byte_data, 8'h11);
      chk("slpout sleep_out", bus.sleep_out, 1);
      chk("slpout disp_on", bus.disp_on, 0);
      send_byte(1'b0, 8'h29);
      chk("dispon byte count", byte_cnt - bc, 2);
      chk("dispon disp_on", bus.disp_on, 1);
      // window 40..279 x 53..187, four pixels
      nop(0, 8'h2A); nop(1, 8'h00); nop(1, 8'h28); nop(1, 8'h01); nop(1, 8'h17);
      nop(0, 8'h2B); nop(1, 8'h00); nop(1, 8'h35); nop(1, 8'h00); nop(1, 8'hBB);
      nop(0, 8'h2C);
      nop(1, 8'hF8); add(1, 8'h00, 1, 9'd40, 9'd53, 16'hF800, 0);
      nop(1, 8'h07); add(1, 8'hE0, 1, 9'd41, 9'd53, 16'h07E0, 0);
      nop(1, 8'h00); add(1, 8'h1F, 1, 9'd42, 9'd53, 16'h001F, 0);
      nop(1, 8'hFF); add(1, 8'hFF, 1, 9'd43, 9'd53, 16'hFFFF, 0);
      // 2x2 window wraps and signals frame end
      nop(0, 8'h2A); nop(1, 8'h00); nop(1, 8'h00); nop(1, 8'h00); nop(1, 8'h01);
      nop(0, 8'h2B); nop(1, 8'h00); nop(1, 8'h00); nop(1, 8'h00); nop(1, 8'h01);
      nop(0, 8'h2C);
      nop(1, 8'h01); add(1, 8'h02, 1, 9'd0, 9'd0, 16'h0102, 0);
      nop(1, 8'h03); add(1, 8'h04, 1, 9'd1, 9'd0, 16'h0304, 0);
      nop(1, 8'h05); add(1, 8'h06, 1, 9'd0, 9'd1, 16'h0506, 0);
      nop(1, 8'h07); add(1, 8'h08, 1, 9'd1, 9'd1, 16'h0708, 1);
      nop(1, 8'h09); add(1, 8'h0A, 1, 9'd0, 9'd0, 16'h090A, 0);
      // a command between the two halves drops the half pixel
      nop(0, 8'h2C); nop(1, 8'hAB); nop(0, 8'h2C);
      nop(1, 8'h12); add(1, 8'h34, 1, 9'd0, 9'd0, 16'h1234, 0);
      foreach (vecs[k]) begin
         pc = pix_cnt;
         bc = byte_cnt;
         send_byte(vecs[k].dc, vecs[k].b);
         chk($sformatf("v%0d byte_data", k), bus.byte_data, vecs[k].b);
         chk($sformatf("v%0d byte_dc", k), bus.byte_dc, vecs[k].dc);
         chk($sformatf("v%0d byte count", k), byte_cnt - bc, 1);
         chk($sformatf("v%0d pix count", k), pix_cnt - pc, vecs[k].pix);
         if (vecs[k].pix) begin
            chk($sformatf("v%0d pix_x", k), lx, vecs[k].x);
            chk($sformatf("v%0d pix_y", k), ly, vecs[k].y);
            chk($sformatf("v%0d pix_rgb", k), lrgb, vecs[k].rgb);
            chk($sformatf("v%0d frame_done", k), lfd, vecs[k].fd);
         end
      end
      bc = byte_cnt;
      send_bits(1'b0, 8'hFF, 5);
      send_byte(1'b0, 8'h3A);
      send_byte(1'b1, 8'h05);
      chk("partial byte count", byte_cnt - bc, 2);
      chk("colmod", bus.colmod, 8'h05);
      send_byte(1'b0, 8'h36);
      send_byte(1'b1, 8'hC0);
      send_byte(1'b1, 8'h77);
      chk("madctl ignores extra", bus.madctl, 8'hC0);
      send_byte(1'b0, 8'h2C);
      send_byte(1'b1, 8'hAB);
      @(negedge clk);
      resetn = 1'b0;
      #1;
      chk("mid rst sleep_out", bus.sleep_out, 0);
      chk("mid rst disp_on", bus.disp_on, 0);
      chk("mid rst colmod", bus.colmod, 0);
      chk("mid rst byte_data", bus.byte_data, 0);
      chk("mid rst pix_x", bus.pix_x, 0);
      chk("mid rst pix_y", bus.pix_y, 0);
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      send_byte(1'b0, 8'h2C);
      pc = pix_cnt;
      for (int i = 0; i < 241; i++) begin
         send_byte(1'b1, 8'h00);
         send_byte(1'b1, 8'h00);
         if (i == 0) begin
            chk("post rst first x", lx, 0);
            chk("post rst first y", ly, 0);
         end
         if (i == 239) begin
            chk("default XE x", lx, 239);
            chk("default XE y", ly, 0);
            chk("default XE no frame", lfd, 0);
         end
         if (i == 240) begin
            chk("row wrap x", lx, 0);
            chk("row wrap y", ly, 1);
         end
      end
      chk("post rst pix count", pix_cnt - pc, 241);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/lcd_spi_rx.md
# lcd_spi_rx

Receiver end of the 4-wire ST7789-style LCD SPI link (SCLK, CS#, D/C#, MOSI), used as a bus monitor or display model. It oversamples the link on a local clock and reassembles bytes. It decodes the command subset our panel driver emits (SLPOUT, DISPON/OFF, MADCTL, COLMOD, CASET, RASET, RAMWR) and streams RGB565 pixels with window coordinates, for frame capture, on-screen checking and simulation scoreboarding.

## Interface
- COORD_W, 9: width of column/row counters; received 16-bit coordinates are truncated to COORD_W LSBs.
- DEF_XE, 239: column-end reset value.
- DEF_YE, 319: row-end reset value.
- clk  in  1  local sampling clock; must be ≥4× SCLK frequency.
- resetn  in  1  reset, asynchronous, active-low.
- spi_sclk  in  1  SPI clock; data sampled on its rising edge.
- spi_cs_n  in  1  chip select, active low.
- spi_dc  in  1  0 = command byte, 1 = parameter/pixel byte.
- spi_mosi  in  1  serial data, MSB first.
- byte_valid  out  1  one-cycle pulse per received byte.
- byte_data  out  8  received byte.
- byte_dc  out  1  D/C# value sampled with bit 0 of the byte.
- pix_valid  out  1  one-cycle pulse per completed pixel.
- pix_x, pix_y  out  COORD_W  coordinates of the pixel.
- pix_rgb  out  16  RGB565 pixel, first byte in [15:8].
- frame_done  out  1  pulse together with the pix_valid of the last pixel of the window.
- sleep_out, disp_on  out  1  panel status flags.
- madctl, colmod  out  8  last MADCTL (0x36) / COLMOD (0x3A) parameter.

## Operation
- All four SPI inputs pass through a common 2-FF synchronizer, so they stay mutually aligned. A rising edge is detected when the synced SCLK goes 0→1 while synced CS# is low.
- On each detected edge, shift synced MOSI into an 8-bit shift register and increment the 3-bit bit counter. On the 8th bit, register byte_data/byte_dc and pulse byte_valid; the counter wraps to 0.
- CS# high clears the bit counter and discards a partial byte. It does NOT alter decoder state, the parameter index or the pixel byte phase, because the driver toggles CS# between every byte and every pixel.
- Decoder states: IDLE, PARAM (collecting parameters of the current command), RAMWR.
- A command byte (dc=0) always aborts the current state, zeroes the parameter index and clears the pixel phase. The next state depends on the opcode:
  - 0x11 sets sleep_out; state becomes IDLE.
  - 0x10 clears sleep_out; state becomes IDLE.
  - 0x29 sets disp_on; 0x28 clears it; state becomes IDLE.
  - 0x36, 0x3A, 0x2A, 0x2B move to PARAM.
  - 0x2C loads the pointer (x=XS, y=YS) and moves to RAMWR.
  - Any other opcode moves to PARAM with its parameters ignored.
- PARAM data bytes:
  - 0x36 / 0x3A: byte 0 is loaded into madctl / colmod.
  - 0x2A: bytes 0..3 are XS[15:8], XS[7:0], XE[15:8], XE[7:0].
  - 0x2B: the same layout for YS/YE.
  - Extra bytes beyond the defined count are ignored.
- RAMWR data bytes:
  - An even byte is latched as the high byte.
  - An odd byte completes the pixel: pulse pix_valid with current x, y, {hi, byte}, then advance the pointer.
- Pointer advance:
  - If x==XE: x←XS, and then if y==YE, y←YS and frame_done pulses; otherwise y←y+1.
  - Otherwise x←x+1, wrapping modulo 2^COORD_W.
  - If XS>XE, x counts up, wraps through 0 and eventually reaches XE.
- A new 0x2C mid-frame restarts at (XS,YS). A CASET/RASET during RAMWR takes effect at the next 0x2C.

## Timing
- Reset values:
  - byte_valid, pix_valid, frame_done, sleep_out, disp_on = 0.
  - byte_data, byte_dc, pix_rgb, madctl, colmod, pix_x, pix_y = 0.
  - XS=YS=0, XE=DEF_XE, YE=DEF_YE; state IDLE; pixel phase even; bit counter 0.
- Latency from the pin SCLK rising edge of bit 0 to byte_valid: 3 clk, covering 2 synchronizer stages and 1 register.
- pix_valid, frame_done and flag/register updates follow 1 clk after byte_valid.
- The pointer update is visible on the cycle after pix_valid.
- SCLK high and low phases must each be ≥2 clk. MOSI and D/C# must be stable for ≥2 clk after the SCLK rising edge.
- A CS# high pulse must be ≥2 clk to be seen; a shorter pulse may be missed. A missed pulse is harmless when the byte is complete.
- resetn assertion mid-byte or mid-frame returns everything to reset values immediately. Reception restarts with the next full byte after CS# and SCLK activity.

## Test plan
- Reset, then send 0x11 then 0x29 (dc=0), with CS# high between bytes → two byte_valid pulses with byte_dc=0; sleep_out=1, then disp_on=1.
- Send CASET 00 28 01 17 and RASET 00 35 00 BB, then 0x2C plus 4 pixels 0xF800, 0x07E0, 0x001F, 0xFFFF with CS# toggled per byte → pix (40,53)=F800, (41,53)=07E0, (42,53)=001F, (43,53)=FFFF.
- Set window 0..1 × 0..1 and write 5 pixels → coordinates (0,0), (1,0), (0,1), (1,1) with frame_done on the 4th, then (0,0) for the 5th.
- Raise CS# after 5 bits, then send a full byte 0x3A, then data 0x05 → no byte_valid for the partial byte; colmod=0x05.
- Send RAMWR, one pixel high byte 0xAB, then command 0x2C, then 0x12 0x34 → no pixel from 0xAB; one pixel 0x1234 at (XS,YS).
- Assert resetn low during RAMWR mid-pixel → all outputs at reset values; XE=239, YE=319; the next RAMWR without CASET starts at (0,0).
